// File: rtl/branch_predictor_v2.sv
// branch_predictor_v2: gshare direction predictor, tagged BTB and circular return-address stack.
//
// Predicts direction and next PC for the fetch PC combinationally, and is trained by resolved
// control-transfer instructions from the ALU. A committed copy of the global history and RAS
// tracks resolved instructions; a speculative copy tracks lookups and is restored from the
// committed copy on alu_flush_i.
//
// Build option: define BP_RAS_EN to include the return-address stacks. Without it, returns
// predict the BTB target (the call/ret bits are still stored in the BTB).
//
// Ports:
//   clk_i          clock, all state on rising edge
//   rst_i          synchronous active-high reset
//   pc_vld_i       fetch PC valid
//   pc_i           fetch PC (word aligned)
//   bp_hit_o       BTB hit for pc_i
//   bp_taken_o     predicted taken
//   bp_pc_o        predicted next PC
//   alu_branch_i   a control-transfer instruction resolves this cycle
//   alu_cond_i     resolved instruction is conditional (0: jal/jalr)
//   alu_call_i     resolved instruction is a call
//   alu_return_i   resolved instruction is a return
//   alu_taken_i    resolved direction
//   alu_flush_i    misprediction, restore speculative state from committed state
//   alu_target_i   resolved target
//   alu_pc_i       PC of the resolved instruction
module branch_predictor_v2 #(
  parameter int unsigned GHR_WIDTH     = 6,
  parameter int unsigned BTB_IDX_WIDTH = 6,
  parameter int unsigned TAG_WIDTH     = 8,
  parameter int unsigned RAS_DEPTH     = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        pc_vld_i,
  input  logic [31:0] pc_i,
  output logic        bp_hit_o,
  output logic        bp_taken_o,
  output logic [31:0] bp_pc_o,
  input  logic        alu_branch_i,
  input  logic        alu_cond_i,
  input  logic        alu_call_i,
  input  logic        alu_return_i,
  input  logic        alu_taken_i,
  input  logic        alu_flush_i,
  input  logic [31:0] alu_target_i,
  input  logic [31:0] alu_pc_i
);

  localparam int unsigned BtbEntries = 1 << BTB_IDX_WIDTH;
  localparam int unsigned PhtEntries = 1 << GHR_WIDTH;

  // BTB storage
  logic [BtbEntries-1:0] btb_valid_q;
  logic [BtbEntries-1:0] btb_cond_q;
  logic [BtbEntries-1:0] btb_call_q;
  logic [BtbEntries-1:0] btb_ret_q;
  logic [TAG_WIDTH-1:0]  btb_tag_q [BtbEntries];
  logic [31:0]           btb_tgt_q [BtbEntries];

  // Direction state
  logic [1:0]           pht_q [PhtEntries];
  logic [GHR_WIDTH-1:0] ghr_q, ghr_d;
  logic [GHR_WIDTH-1:0] ghr_spec_q, ghr_spec_d;

  // Lookup side
  logic [BTB_IDX_WIDTH-1:0] lk_idx;
  logic [TAG_WIDTH-1:0]     lk_tag;
  logic [GHR_WIDTH-1:0]     lk_pht_idx;
  logic [31:0]              pc_plus4;
  logic                     lk_cond;
  logic                     lk_call;
  logic                     lk_ret;

  // Update side
  logic [BTB_IDX_WIDTH-1:0] up_idx;
  logic [TAG_WIDTH-1:0]     up_tag;
  logic [GHR_WIDTH-1:0]     up_pht_idx;
  logic [1:0]               pht_old;
  logic [1:0]               pht_new;

  assign lk_idx     = pc_i[2 +: BTB_IDX_WIDTH];
  assign lk_tag     = pc_i[2 + BTB_IDX_WIDTH +: TAG_WIDTH];
  assign lk_pht_idx = ghr_spec_q ^ pc_i[2 +: GHR_WIDTH];
  assign pc_plus4   = pc_i + 32'd4;
  assign lk_cond    = btb_cond_q[lk_idx];
  assign lk_call    = btb_call_q[lk_idx];
  assign lk_ret     = btb_ret_q[lk_idx];

  assign up_idx     = alu_pc_i[2 +: BTB_IDX_WIDTH];
  assign up_tag     = alu_pc_i[2 + BTB_IDX_WIDTH +: TAG_WIDTH];
  // Training indexes with the committed history as it was before this branch shifts it in.
  assign up_pht_idx = ghr_q ^ alu_pc_i[2 +: GHR_WIDTH];
  assign pht_old    = pht_q[up_pht_idx];

  // Outputs are forced to the fall-through prediction while reset is asserted.
  assign bp_hit_o   = ~rst_i & pc_vld_i & btb_valid_q[lk_idx] & (btb_tag_q[lk_idx] == lk_tag);
  assign bp_taken_o = bp_hit_o & (~lk_cond | pht_q[lk_pht_idx][1]);

  always_comb begin
    pht_new = pht_old;
    if (alu_taken_i) begin
      if (pht_old != 2'b11) pht_new = pht_old + 2'b01;
    end else begin
      if (pht_old != 2'b00) pht_new = pht_old - 2'b01;
    end
  end

  always_comb begin
    ghr_d = ghr_q;
    if (alu_branch_i && alu_cond_i) ghr_d = {ghr_q[GHR_WIDTH-2:0], alu_taken_i};
  end

  always_comb begin
    ghr_spec_d = ghr_spec_q;
    if (alu_flush_i) begin
      ghr_spec_d = ghr_d;
    end else if (bp_hit_o && lk_cond) begin
      ghr_spec_d = {ghr_spec_q[GHR_WIDTH-2:0], bp_taken_o};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      btb_valid_q <= '0;
      btb_cond_q  <= '0;
      btb_call_q  <= '0;
      btb_ret_q   <= '0;
      for (int i = 0; i < int'(PhtEntries); i++) pht_q[i] <= 2'b01;
      ghr_q       <= '0;
      ghr_spec_q  <= '0;
    end else begin
      if (alu_branch_i) begin
        btb_valid_q[up_idx] <= 1'b1;
        btb_cond_q[up_idx]  <= alu_cond_i;
        btb_call_q[up_idx]  <= alu_call_i;
        btb_ret_q[up_idx]   <= alu_return_i;
        if (alu_cond_i) pht_q[up_pht_idx] <= pht_new;
      end
      ghr_q      <= ghr_d;
      ghr_spec_q <= ghr_spec_d;
    end
  end

  // Tag and target need no reset: they are qualified by btb_valid_q.
  always_ff @(posedge clk_i) begin
    if (alu_branch_i) begin
      btb_tag_q[up_idx] <= up_tag;
      btb_tgt_q[up_idx] <= alu_target_i;
    end
  end

`ifdef BP_RAS_EN
  localparam int unsigned RasPtrW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned RasCntW = $clog2(RAS_DEPTH + 1);
  localparam logic [RasPtrW-1:0] PtrOne  = RasPtrW'(1);
  localparam logic [RasCntW-1:0] CntOne  = RasCntW'(1);
  localparam logic [RasCntW-1:0] CntFull = RasCntW'(RAS_DEPTH);

  // ptr points at the next free slot; the top of stack is ptr-1. Writing at ptr while full
  // overwrites the oldest entry because the array wraps.
  logic [31:0]        cras_q [RAS_DEPTH];
  logic [31:0]        cras_d [RAS_DEPTH];
  logic [31:0]        sras_q [RAS_DEPTH];
  logic [31:0]        sras_d [RAS_DEPTH];
  logic [RasPtrW-1:0] cras_ptr_q, cras_ptr_d, sras_ptr_q, sras_ptr_d;
  logic [RasCntW-1:0] cras_cnt_q, cras_cnt_d, sras_cnt_q, sras_cnt_d;
  logic               c_we, s_we;
  logic [RasPtrW-1:0] c_wptr, s_wptr;
  logic [31:0]        ras_top;

  function automatic void ras_step(input  logic               push,
                                   input  logic               pop,
                                   input  logic [RasPtrW-1:0] ptr,
                                   input  logic [RasCntW-1:0] cnt,
                                   output logic               we,
                                   output logic [RasPtrW-1:0] wptr,
                                   output logic [RasPtrW-1:0] ptr_n,
                                   output logic [RasCntW-1:0] cnt_n);
    we    = 1'b0;
    wptr  = ptr;
    ptr_n = ptr;
    cnt_n = cnt;
    if (push && pop) begin
      // Replace top; on an empty stack this degenerates to a plain push.
      we = 1'b1;
      if (cnt == '0) begin
        ptr_n = ptr + PtrOne;
        cnt_n = CntOne;
      end else begin
        wptr = ptr - PtrOne;
      end
    end else if (push) begin
      we    = 1'b1;
      ptr_n = ptr + PtrOne;
      if (cnt != CntFull) cnt_n = cnt + CntOne;
    end else if (pop) begin
      if (cnt != '0) begin
        ptr_n = ptr - PtrOne;
        cnt_n = cnt - CntOne;
      end
    end
  endfunction

  always_comb begin
    cras_d = cras_q;
    sras_d = sras_q;
    ras_step(alu_branch_i & alu_call_i, alu_branch_i & alu_return_i, cras_ptr_q, cras_cnt_q,
             c_we, c_wptr, cras_ptr_d, cras_cnt_d);
    if (c_we) cras_d[c_wptr] = alu_pc_i + 32'd4;
    ras_step(bp_hit_o & lk_call, bp_hit_o & lk_ret, sras_ptr_q, sras_cnt_q,
             s_we, s_wptr, sras_ptr_d, sras_cnt_d);
    if (s_we) sras_d[s_wptr] = pc_plus4;
    if (alu_flush_i) begin
      sras_d     = cras_d;
      sras_ptr_d = cras_ptr_d;
      sras_cnt_d = cras_cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cras_ptr_q <= '0;
      cras_cnt_q <= '0;
      sras_ptr_q <= '0;
      sras_cnt_q <= '0;
    end else begin
      cras_ptr_q <= cras_ptr_d;
      cras_cnt_q <= cras_cnt_d;
      sras_ptr_q <= sras_ptr_d;
      sras_cnt_q <= sras_cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    cras_q <= cras_d;
    sras_q <= sras_d;
  end

  assign ras_top = sras_q[sras_ptr_q - PtrOne];

  always_comb begin
    bp_pc_o = pc_plus4;
    if (bp_taken_o) begin
      if (lk_ret && (sras_cnt_q != '0)) bp_pc_o = ras_top;
      else                              bp_pc_o = btb_tgt_q[lk_idx];
    end
  end
`else
  logic unused_ras;
  assign unused_ras = ^{lk_call, lk_ret, alu_pc_i};

  always_comb begin
    bp_pc_o = pc_plus4;
    if (bp_taken_o) bp_pc_o = btb_tgt_q[lk_idx];
  end
`endif

endmodule

// File: tb/tb_branch_predictor_v2.sv
module tb_branch_predictor_v2;

  localparam int RasDepth = 4;

  logic        clk = 1'b0;
  logic        rst_i, pc_vld_i, alu_branch_i, alu_cond_i, alu_call_i, alu_return_i;
  logic        alu_taken_i, alu_flush_i;
  logic [31:0] pc_i, alu_target_i, alu_pc_i, bp_pc_o;
  logic        bp_hit_o, bp_taken_o;

  int checks = 0;
  int errors = 0;

  branch_predictor_v2 dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .pc_vld_i     (pc_vld_i),
    .pc_i         (pc_i),
    .bp_hit_o     (bp_hit_o),
    .bp_taken_o   (bp_taken_o),
    .bp_pc_o      (bp_pc_o),
    .alu_branch_i (alu_branch_i),
    .alu_cond_i   (alu_cond_i),
    .alu_call_i   (alu_call_i),
    .alu_return_i (alu_return_i),
    .alu_taken_i  (alu_taken_i),
    .alu_flush_i  (alu_flush_i),
    .alu_target_i (alu_target_i),
    .alu_pc_i     (alu_pc_i)
  );

  always #5 clk = ~clk;

  // Reference model: plain arrays plus queues for the stacks (back = top of stack).
  typedef int unsigned uq_t[$];
  bit          m_valid [64];
  int unsigned m_tag   [64];
  int unsigned m_tgt   [64];
  bit          m_cond  [64];
  bit          m_call  [64];
  bit          m_ret   [64];
  int          m_pht   [64];
  int unsigned m_ghr, m_ghrs;
  uq_t         m_cras, m_sras;

  bit          e_hit, e_taken, e_cond, e_call, e_ret;
  int unsigned e_pc;

  function automatic uq_t ras_next(uq_t q, bit push, bit pop, int unsigned val);
    if (push && pop) begin
      if (q.size() != 0) void'(q.pop_back());
      q.push_back(val);
    end else if (push) begin
      q.push_back(val);
      if (q.size() > RasDepth) void'(q.pop_front());
    end else if (pop) begin
      if (q.size() != 0) void'(q.pop_back());
    end
    return q;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 0;
      m_pht[i]   = 1;
    end
    m_ghr  = 0;
    m_ghrs = 0;
    m_cras = {};
    m_sras = {};
  endtask

  task automatic model_predict();
    int unsigned p, idx, li;
    p      = pc_i;
    idx    = (p >> 2) % 64;
    li     = (m_ghrs ^ ((p >> 2) % 64)) % 64;
    e_hit  = !rst_i && pc_vld_i && m_valid[idx] && (m_tag[idx] == ((p >> 8) % 256));
    e_cond = e_hit && m_cond[idx];
    e_call = e_hit && m_call[idx];
    e_ret  = e_hit && m_ret[idx];
    e_taken = e_hit && (!m_cond[idx] || m_pht[li] >= 2);
    e_pc   = p + 4;
    if (e_taken) begin
`ifdef BP_RAS_EN
      if (m_ret[idx] && m_sras.size() != 0) e_pc = m_sras[m_sras.size()-1];
      else e_pc = m_tgt[idx];
`else
      e_pc = m_tgt[idx];
`endif
    end
  endtask

  task automatic model_update();
    int unsigned a, idx, ui;
    if (rst_i) begin
      model_reset();
      return;
    end
    a = alu_pc_i;
    if (alu_branch_i) begin
      idx = (a >> 2) % 64;
      m_valid[idx] = 1;
      m_tag[idx]   = (a >> 8) % 256;
      m_tgt[idx]   = alu_target_i;
      m_cond[idx]  = alu_cond_i;
      m_call[idx]  = alu_call_i;
      m_ret[idx]   = alu_return_i;
      if (alu_cond_i) begin
        ui = (m_ghr ^ ((a >> 2) % 64)) % 64;
        if (alu_taken_i && m_pht[ui] < 3) m_pht[ui]++;
        if (!alu_taken_i && m_pht[ui] > 0) m_pht[ui]--;
        m_ghr = ((m_ghr * 2) + (alu_taken_i ? 1 : 0)) % 64;
      end
      m_cras = ras_next(m_cras, alu_call_i, alu_return_i, a + 4);
    end
    if (alu_flush_i) begin
      m_ghrs = m_ghr;
      m_sras = m_cras;
    end else if (e_hit) begin
      if (e_cond) m_ghrs = ((m_ghrs * 2) + (e_taken ? 1 : 0)) % 64;
      m_sras = ras_next(m_sras, e_call, e_ret, pc_i + 4);
    end
  endtask

  // Drive a cycle's inputs, then settle at the falling edge and compute the expected outputs.
  task automatic drive(input bit rst, input bit vld, input logic [31:0] p, input bit br,
                       input bit cond, input bit call, input bit ret, input bit tkn,
                       input bit flush, input logic [31:0] tgt, input logic [31:0] apc);
    rst_i = rst; pc_vld_i = vld; pc_i = p;
    alu_branch_i = br; alu_cond_i = cond; alu_call_i = call; alu_return_i = ret;
    alu_taken_i = tkn; alu_flush_i = flush; alu_target_i = tgt; alu_pc_i = apc;
    @(negedge clk);
    model_predict();
  endtask

  task automatic commit();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      // Random training traffic while reset is held must leave no trace.
      drive(1, 1, 32'h100, 1, 1'($urandom), 1'($urandom), 1'($urandom), 1, 1'($urandom),
            32'h80, 32'h100);
      checks++;
      if (bp_hit_o !== 1'b0 || bp_taken_o !== 1'b0 || bp_pc_o !== 32'h104) begin
        errors++;
        $display("FAIL reset_during hit=%0b taken=%0b pc=%h want 0 0 00000104",
                 bp_hit_o, bp_taken_o, bp_pc_o);
      end
      commit();
    end
    drive(0, 1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (bp_hit_o !== 1'b0 || bp_taken_o !== 1'b0 || bp_pc_o !== 32'h104) begin
      errors++;
      $display("FAIL reset_after hit=%0b taken=%0b pc=%h want 0 0 00000104",
               bp_hit_o, bp_taken_o, bp_pc_o);
    end
    commit();
  endtask

  task automatic test_jal();
    // Lookup of the entry being written this cycle must still see the old contents.
    drive(0, 1, 32'h200, 1, 0, 0, 0, 1, 0, 32'h400, 32'h200);
    checks++;
    if (bp_hit_o !== 1'b0 || bp_pc_o !== 32'h204) begin
      errors++;
      $display("FAIL jal_same_cycle hit=%0b pc=%h want 0 00000204", bp_hit_o, bp_pc_o);
    end
    commit();
    drive(0, 1, 32'h200, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (bp_hit_o !== 1'b1 || bp_taken_o !== 1'b1 || bp_pc_o !== 32'h400) begin
      errors++;
      $display("FAIL jal_hit hit=%0b taken=%0b pc=%h want 1 1 00000400",
               bp_hit_o, bp_taken_o, bp_pc_o);
    end
    commit();
  endtask

  task automatic test_cond();
    drive(0, 0, 32'h0, 1, 1, 0, 0, 0, 0, 32'h80, 32'h100);
    commit();
    drive(0, 1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (bp_hit_o !== 1'b1 || bp_taken_o !== 1'b0 || bp_pc_o !== 32'h104) begin
      errors++;
      $display("FAIL cond_not_taken hit=%0b taken=%0b pc=%h want 1 0 00000104",
               bp_hit_o, bp_taken_o, bp_pc_o);
    end
    commit();
    // Invalid fetch never hits.
    drive(0, 0, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (bp_hit_o !== 1'b0 || bp_pc_o !== 32'h104) begin
      errors++;
      $display("FAIL pc_vld_low hit=%0b pc=%h want 0 00000104", bp_hit_o, bp_pc_o);
    end
    commit();
  endtask

  task automatic test_call_ret();
    logic [31:0] want;
    drive(0, 0, 32'h0, 1, 0, 1, 0, 1, 0, 32'h1000, 32'h300);
    commit();
    drive(0, 0, 32'h0, 1, 0, 0, 1, 1, 0, 32'h5000, 32'h1010);
    commit();
    drive(0, 1, 32'h300, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (bp_taken_o !== 1'b1 || bp_pc_o !== 32'h1000) begin
      errors++;
      $display("FAIL call_lookup taken=%0b pc=%h want 1 00001000", bp_taken_o, bp_pc_o);
    end
    commit();
`ifdef BP_RAS_EN
    want = 32'h304;
`else
    want = 32'h5000;
`endif
    drive(0, 1, 32'h1010, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (bp_taken_o !== 1'b1 || bp_pc_o !== want) begin
      errors++;
      $display("FAIL ret_lookup taken=%0b pc=%h want 1 %h", bp_taken_o, bp_pc_o, want);
    end
    commit();
  endtask

  task automatic test_flush();
    drive(0, 1, 32'h300, 0, 0, 0, 0, 0, 0, 0, 0);
    commit();
    // Flush with a non-call branch; the same-cycle call lookup must not push.
    drive(0, 1, 32'h300, 1, 0, 0, 0, 1, 1, 32'h400, 32'h200);
    checks++;
    if (bp_hit_o !== 1'b1 || bp_pc_o !== 32'h1000) begin
      errors++;
      $display("FAIL flush_cycle_lookup hit=%0b pc=%h want 1 00001000", bp_hit_o, bp_pc_o);
    end
    commit();
    drive(0, 1, 32'h1010, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (bp_taken_o !== 1'b1 || bp_pc_o !== 32'h5000) begin
      errors++;
      $display("FAIL flush_ret taken=%0b pc=%h want 1 00005000", bp_taken_o, bp_pc_o);
    end
    commit();
  endtask

  task automatic test_ras_overflow();
    logic [31:0] want [5];
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 32'h0, 1, 0, 1, 0, 1, 0, 32'h1000, 32'h300 + 32'(4 * i));
      commit();
    end
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 32'h300 + 32'(4 * i), 0, 0, 0, 0, 0, 0, 0, 0);
      commit();
    end
    // Re-train the return; it aliases the 0x310 call entry, which is no longer needed.
    drive(0, 0, 32'h0, 1, 0, 0, 1, 1, 0, 32'h5000, 32'h1010);
    commit();
`ifdef BP_RAS_EN
    want[0] = 32'h314; want[1] = 32'h310; want[2] = 32'h30C; want[3] = 32'h308;
`else
    want[0] = 32'h5000; want[1] = 32'h5000; want[2] = 32'h5000; want[3] = 32'h5000;
`endif
    want[4] = 32'h5000;
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 32'h1010, 0, 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (bp_pc_o !== want[i]) begin
        errors++;
        $display("FAIL ras_overflow_pop%0d pc=%h want %h", i, bp_pc_o, want[i]);
      end
      commit();
    end
  endtask

  task automatic test_random();
    logic [31:0] p, a, t;
    bit          br, cond, call, ret, tkn, flush, rst;
    int          kind;
    for (int n = 0; n < 1500; n++) begin
      p    = 32'(($urandom_range(0, 2) * 32'h1000) + 4 * $urandom_range(0, 7));
      a    = 32'(($urandom_range(0, 2) * 32'h1000) + 4 * $urandom_range(0, 7));
      t    = 32'(4 * $urandom_range(0, 32'h3FFF));
      br   = ($urandom_range(0, 1) == 1);
      kind = $urandom_range(0, 5);
      cond = (kind <= 1);
      call = (kind == 3 || kind == 5);
      ret  = (kind == 4 || kind == 5);
      tkn  = cond ? 1'($urandom) : 1'b1;
      flush = ($urandom_range(0, 9) == 0);
      rst  = ($urandom_range(0, 99) == 0);
      drive(rst, $urandom_range(0, 7) != 0, p, br, cond, call, ret, tkn, flush, t, a);
      checks++;
      if (bp_hit_o !== e_hit || bp_taken_o !== e_taken || bp_pc_o !== e_pc) begin
        errors++;
        $display("FAIL random_%0d pc=%h got hit=%0b taken=%0b npc=%h want %0b %0b %h",
                 n, p, bp_hit_o, bp_taken_o, bp_pc_o, e_hit, e_taken, e_pc);
      end
      commit();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_jal();
    test_cond();
    test_call_ret();
    test_flush();
    test_ras_overflow();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predictor_v2.md
# branch_predictor_v2

Parametrised gshare branch predictor with a tagged BTB and a circular return-address stack (RAS). It sits in the PC/IF stage. It predicts direction and target for the fetch PC in the same cycle. It is trained by resolved control-transfer instructions from the ALU and recovers its speculative history and RAS on a misprediction flush.

## Interface
- GHR_WIDTH, 6: global history bits; PHT has 2^GHR_WIDTH 2-bit counters.
- BTB_IDX_WIDTH, 6: BTB index bits; BTB has 2^BTB_IDX_WIDTH entries.
- TAG_WIDTH, 8: partial tag bits stored per BTB entry.
- RAS_DEPTH, 4: RAS entries, power of two ≥ 2.
- CLK  input  1  clock, all state on rising edge.
- RST  input  1  synchronous, active-high reset.
- pc_vld  input  1  fetch PC valid.
- pc  input  32  fetch PC, word aligned.
- bp_hit  output  1  BTB hit for pc.
- bp_taken  output  1  predicted taken.
- bp_pc  output  32  predicted next PC.
- alu_branch  input  1  a control-transfer instruction resolves this cycle.
- alu_cond  input  1  resolved instruction is conditional; 0 means jal/jalr.
- alu_call  input  1  resolved instruction is a call.
- alu_return  input  1  resolved instruction is a return.
- alu_taken  input  1  resolved direction.
- alu_flush  input  1  misprediction; restore speculative state.
- alu_target  input  32  resolved target.
- alu_pc  input  32  PC of the resolved instruction.

## Operation
- **BTB lookup.**
  - idx = pc[2+:BTB_IDX_WIDTH]; tag = pc[2+BTB_IDX_WIDTH+:TAG_WIDTH].
  - Each entry holds valid, tag, target, cond, call, ret.
  - bp_hit = pc_vld & valid[idx] & (tag match).
- **PHT.**
  - Lookup index = ghr_spec ^ pc[2+:GHR_WIDTH].
  - Update index = ghr ^ alu_pc[2+:GHR_WIDTH], using the committed history before its shift.
  - Counters are 2-bit saturating: +1 on taken, −1 on not taken. Reset value is 01.
- **Direction.** bp_taken = bp_hit & (~cond | pht[lookup][1]).
- **Target.**
  - If bp_taken & ret & RAS spec count ≠ 0: bp_pc = spec RAS top.
  - Else if bp_taken: bp_pc = BTB target.
  - Else: bp_pc = pc+4. All arithmetic is mod 2^32.
- **BTB update.** On alu_branch, write all fields of entry alu_pc idx: valid=1, tag, alu_target, alu_cond, alu_call, alu_return.
- **Committed state update (on alu_branch).**
  - PHT counter updates only if alu_cond.
  - ghr shifts left by one, LSB = alu_taken, only if alu_cond.
  - Committed RAS is updated by alu_call/alu_return (rules below).
- **Speculative state, when alu_flush = 0 and bp_hit.**
  - ghr_spec shifts in the prediction if cond.
  - Spec RAS pushes pc+4 on call and pops on ret.
- **Flush.**
  - alu_flush copies the committed state, including the effect of the same-cycle alu_branch, into ghr_spec and the spec RAS.
  - Flush overrides same-cycle lookup effects.
  - Flush without alu_branch copies the committed state unchanged.
- **RAS (committed and speculative copies).**
  - Circular array with pointer and count (0..RAS_DEPTH).
  - Push when full: overwrite the oldest entry; count stays RAS_DEPTH.
  - Pop when empty: no change; the target falls back to the BTB.
  - Call & return together: replace top (pop then push); count unchanged, or becomes 1 if it was 0.
- **Reset.** BTB valid all 0, PHT all 01, ghr = ghr_spec = 0, both RAS counts = 0 and pointers = 0.
- **Outputs.** Outputs are combinational. During and after reset: bp_hit=0, bp_taken=0, bp_pc=pc+4.

## Timing
- Prediction has zero latency: outputs are combinational from pc and the current state.
- All updates become visible to a lookup one cycle after the alu_branch/alu_flush/lookup edge.
- Same-cycle lookup and update of the same BTB or PHT entry: the lookup sees the old contents.
- Reset mid-operation clears all state at the next edge, whatever the alu_* inputs are.

## Configuration
- BP_RAS_EN defined: the RAS is present and behaves as above.
- BP_RAS_EN undefined: no RAS storage. Returns predict the BTB target; the call/ret BTB bits are still stored.

## Test plan
- Reset, then pc=0x100, pc_vld=1 → bp_hit=0, bp_taken=0, bp_pc=0x104.
- Resolve jal at alu_pc=0x200, alu_target=0x400, alu_cond=0 → next cycle pc=0x200 gives bp_hit=1, bp_taken=1, bp_pc=0x400.
- Resolve cond branch at 0x100, not taken, target 0x80 → lookup of 0x100 gives hit=1, taken=0, bp_pc=0x104; committed ghr stays 0.
- Train call at 0x300 (target 0x1000) and return at 0x1010 (target 0x5000). Then look up 0x300, then 0x1010 → the second lookup gives bp_taken=1, bp_pc=0x304.
- Five speculative calls at 0x300..0x310 with RAS_DEPTH=4, then five return lookups → bp_pc = 0x314, 0x310, 0x30C, 0x308, then the BTB target 0x5000.
- Spec push of 0x304, then alu_flush with a non-call alu_branch → the return lookup gives bp_pc=0x5000 and ghr_spec equals ghr.
- Build without BP_RAS_EN, repeat the call/return scenario → bp_pc=0x5000.
